// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester (IF / LSU) arbiter in front of a single
// synchronous-read memory bus. One transaction is in flight at a time. The
// address is held stable while a read completes, and the read data returns
// to the owner with a one-cycle rvalid pulse. Stores complete in the grant
// cycle and never enter WAIT.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for a round-robin
// tie-break. Without it, the LSU has fixed priority on a tie.
module mem_bus_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              lsu_req,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wrdata,
  input  logic              lsu_wren,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wrdata,
  output logic              bus_wren,
  input  logic [DATA_W-1:0] bus_rddata,
  output logic              busy
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("mem_bus_arbiter: RD_LATENCY must be in 1..3");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              owner_lsu_q, owner_lsu_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;

  // While reset is asserted, requests are masked so that grants, bus_wren
  // and the address mux all read as idle.
  logic if_req_v, lsu_req_v, win_lsu;
  assign if_req_v  = if_req & rst;
  assign lsu_req_v = lsu_req & rst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_gnt: 1 = LSU, 0 = IF. On a tie the other requester wins.
  logic last_gnt_q, last_gnt_d;

  // Tie-break selection: round-robin against the previous winner.
  always_comb begin
    win_lsu = lsu_req_v;
    if (if_req_v && lsu_req_v) win_lsu = ~last_gnt_q;
  end

  // Previous-winner register.
  always_ff @(posedge clk) begin
    if (!rst) last_gnt_q <= 1'b1;
    else      last_gnt_q <= last_gnt_d;
  end
`else
  // Tie-break selection: the LSU always wins.
  always_comb begin
    win_lsu = lsu_req_v;
  end
`endif

  // Next-state, grant and bus-mux logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wrdata_d     = wrdata_q;
    owner_lsu_d  = owner_lsu_q;
    if_rdata_d   = if_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    if_rvalid_d  = 1'b0;
    lsu_rvalid_d = 1'b0;
    if_gnt       = 1'b0;
    lsu_gnt      = 1'b0;
    bus_addr     = addr_q;
    bus_wrdata   = wrdata_q;
    bus_wren     = 1'b0;
    busy         = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_gnt_d   = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req_v || lsu_req_v) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_gnt_d = win_lsu;
`endif
          owner_lsu_d = win_lsu;
          if (win_lsu) begin
            lsu_gnt    = 1'b1;
            bus_addr   = lsu_addr;
            bus_wrdata = lsu_wrdata;
            bus_wren   = lsu_wren;
            addr_d     = lsu_addr;
            wrdata_d   = lsu_wrdata;
            // A store finishes in its grant cycle, so the bus stays free.
            if (!lsu_wren) begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end
          end else begin
            // Fetches carry no write data, so wrdata_q keeps its last value.
            if_gnt   = 1'b1;
            bus_addr = if_addr;
            addr_d   = if_addr;
            state_d  = WAIT;
            cnt_d    = CNT_INIT;
          end
        end
      end
      WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = IDLE;
          if (owner_lsu_q) begin
            lsu_rdata_d  = bus_rddata;
            lsu_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = bus_rddata;
            if_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, transaction and return-data registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      wrdata_q     <= '0;
      owner_lsu_q  <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wrdata_q     <= wrdata_d;
      owner_lsu_q  <= owner_lsu_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      if_rvalid_q  <= if_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign if_rvalid  = if_rvalid_q;
  assign lsu_rvalid = lsu_rvalid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: one instance with RD_LATENCY=1 (a_*) and
// one with RD_LATENCY=3 (b_*). Expected read returns are queued when a grant
// is issued, and negedge monitors pop and compare them when rvalid appears.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_if_req, a_if_gnt, a_if_rvalid, a_lsu_req, a_lsu_wren, a_lsu_gnt, a_lsu_rvalid;
  logic        a_bus_wren, a_busy;
  logic [31:0] a_if_addr, a_if_rdata, a_lsu_addr, a_lsu_wrdata, a_lsu_rdata;
  logic [31:0] a_bus_addr, a_bus_wrdata, a_rd;

  logic        b_if_req, b_if_gnt, b_if_rvalid, b_lsu_req, b_lsu_wren, b_lsu_gnt, b_lsu_rvalid;
  logic        b_bus_wren, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_lsu_addr, b_lsu_wrdata, b_lsu_rdata;
  logic [31:0] b_bus_addr, b_bus_wrdata, b_rd;

  mem_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .lsu_req(a_lsu_req), .lsu_addr(a_lsu_addr), .lsu_wrdata(a_lsu_wrdata),
    .lsu_wren(a_lsu_wren), .lsu_gnt(a_lsu_gnt), .lsu_rvalid(a_lsu_rvalid),
    .lsu_rdata(a_lsu_rdata), .bus_addr(a_bus_addr), .bus_wrdata(a_bus_wrdata),
    .bus_wren(a_bus_wren), .bus_rddata(a_rd), .busy(a_busy)
  );

  mem_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LATENCY(3)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .lsu_req(b_lsu_req), .lsu_addr(b_lsu_addr), .lsu_wrdata(b_lsu_wrdata),
    .lsu_wren(b_lsu_wren), .lsu_gnt(b_lsu_gnt), .lsu_rvalid(b_lsu_rvalid),
    .lsu_rdata(b_lsu_rdata), .bus_addr(b_bus_addr), .bus_wrdata(b_bus_wrdata),
    .bus_wren(b_bus_wren), .bus_rddata(b_rd), .busy(b_busy)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit FIRST_LSU = 1'b0;
`else
  localparam bit FIRST_LSU = 1'b1;
`endif
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  typedef struct {
    bit          is_lsu;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input bit is_lsu, input logic [31:0] data, input int c);
    exp_t e;
    e.is_lsu = is_lsu;
    e.data   = data;
    e.cyc    = c;
    return e;
  endfunction

  // Scoreboard monitor, RD_LATENCY=1 instance.
  always @(negedge clk) begin
    if (a_if_rvalid === 1'b1 || a_lsu_rvalid === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rvalid", {a_if_rvalid, a_lsu_rvalid}, 2'b00);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rv_if", a_if_rvalid, !e.is_lsu);
        chk("a_rv_lsu", a_lsu_rvalid, e.is_lsu);
        chk("a_rv_data", e.is_lsu ? a_lsu_rdata : a_if_rdata, e.data);
        chk("a_rv_cycle", cyc, e.cyc);
      end
    end
  end

  // Scoreboard monitor, RD_LATENCY=3 instance.
  always @(negedge clk) begin
    if (b_if_rvalid === 1'b1 || b_lsu_rvalid === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rvalid", {b_if_rvalid, b_lsu_rvalid}, 2'b00);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rv_if", b_if_rvalid, !e.is_lsu);
        chk("b_rv_lsu", b_lsu_rvalid, e.is_lsu);
        chk("b_rv_data", e.is_lsu ? b_lsu_rdata : b_if_rdata, e.data);
        chk("b_rv_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b0;
    a_if_req = 1'b1; a_if_addr = 32'h0040_0100; a_lsu_req = 1'b1; a_lsu_wren = 1'b1;
    a_lsu_addr = 32'h1001_0100; a_lsu_wrdata = 32'h1234_5678; a_rd = JUNK;
    b_if_req = 1'b1; b_if_addr = 32'h0040_0200; b_lsu_req = 1'b1; b_lsu_wren = 1'b0;
    b_lsu_addr = 32'h1001_0200; b_lsu_wrdata = 32'h8765_4321; b_rd = JUNK;

    // Reset held for 3 edges with both requests high.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", {a_if_gnt, a_lsu_gnt, b_if_gnt, b_lsu_gnt}, 4'b0);
    chk("rst_rvalid", {a_if_rvalid, a_lsu_rvalid, b_if_rvalid, b_lsu_rvalid}, 4'b0);
    chk("rst_wren_busy", {a_bus_wren, b_bus_wren, a_busy, b_busy}, 4'b0);
    chk("rst_bus_addr", a_bus_addr, 32'h0);
    chk("rst_bus_wrdata", a_bus_wrdata, 32'h0);
    chk("rst_b_bus_addr", b_bus_addr, 32'h0);
    chk("rst_rdata", {a_if_rdata, a_lsu_rdata}, 64'h0);

    nxt();
    rst = 1'b1;
    a_if_req = 1'b0; a_lsu_req = 1'b0; a_lsu_wren = 1'b0;
    b_if_req = 1'b0; b_lsu_req = 1'b0;

    // Single IF fetch, RD_LATENCY=1.
    nxt();
    a_if_req = 1'b1; a_if_addr = 32'h0040_0004;
    @(negedge clk);
    chk("fetch_if_gnt", a_if_gnt, 1'b1);
    chk("fetch_lsu_gnt", a_lsu_gnt, 1'b0);
    chk("fetch_addr_c0", a_bus_addr, 32'h0040_0004);
    chk("fetch_busy_c0", a_busy, 1'b0);
    qa.push_back(mk(1'b0, 32'h00A0_0093, cyc + 2));
    nxt();
    a_if_req = 1'b0; a_if_addr = 32'h0; a_rd = 32'h00A0_0093;
    @(negedge clk);
    chk("fetch_addr_c1", a_bus_addr, 32'h0040_0004);
    chk("fetch_busy_c1", a_busy, 1'b1);
    chk("fetch_gnt_c1", a_if_gnt, 1'b0);
    nxt();
    a_rd = JUNK;
    @(negedge clk);
    chk("fetch_busy_c2", a_busy, 1'b0);
    chk("fetch_lsu_rdata_kept", a_lsu_rdata, 32'h0);
    nxt();
    @(negedge clk);
    chk("fetch_if_rdata_held", a_if_rdata, 32'h00A0_0093);

    // Back-to-back LSU stores.
    nxt();
    a_lsu_req = 1'b1; a_lsu_wren = 1'b1; a_lsu_addr = 32'h1001_0008; a_lsu_wrdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st1_gnt", a_lsu_gnt, 1'b1);
    chk("st1_wren", a_bus_wren, 1'b1);
    chk("st1_addr", a_bus_addr, 32'h1001_0008);
    chk("st1_wrdata", a_bus_wrdata, 32'hDEAD_BEEF);
    chk("st1_busy", a_busy, 1'b0);
    nxt();
    a_lsu_addr = 32'h1001_000C; a_lsu_wrdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("st2_gnt", a_lsu_gnt, 1'b1);
    chk("st2_wren", a_bus_wren, 1'b1);
    chk("st2_addr", a_bus_addr, 32'h1001_000C);
    chk("st2_busy", a_busy, 1'b0);
    nxt();
    a_lsu_req = 1'b0; a_lsu_wren = 1'b0;
    @(negedge clk);
    chk("st_after_wren", a_bus_wren, 1'b0);
    chk("st_after_addr", a_bus_addr, 32'h1001_000C);
    chk("st_after_wrdata", a_bus_wrdata, 32'hCAFE_F00D);
    chk("st_after_busy", a_busy, 1'b0);
    nxt();

    // Simultaneous loads; both requests held until their own grant.
    nxt();
    a_if_req = 1'b1; a_if_addr = 32'h0040_0000;
    a_lsu_req = 1'b1; a_lsu_wren = 1'b0; a_lsu_addr = 32'h1001_0000;
    @(negedge clk);
    chk("tie1_if_gnt", a_if_gnt, !FIRST_LSU);
    chk("tie1_lsu_gnt", a_lsu_gnt, FIRST_LSU);
    chk("tie1_addr", a_bus_addr, FIRST_LSU ? 32'h1001_0000 : 32'h0040_0000);
    qa.push_back(mk(FIRST_LSU, 32'h1111_2222, cyc + 2));
    nxt();
    if (FIRST_LSU) a_lsu_req = 1'b0;
    else           a_if_req = 1'b0;
    a_rd = 32'h1111_2222;
    @(negedge clk);
    chk("tie_wait_busy", a_busy, 1'b1);
    chk("tie_wait_gnt", {a_if_gnt, a_lsu_gnt}, 2'b00);
    nxt();
    a_rd = JUNK;
    @(negedge clk);
    chk("tie2_if_gnt", a_if_gnt, FIRST_LSU);
    chk("tie2_lsu_gnt", a_lsu_gnt, !FIRST_LSU);
    chk("tie2_addr", a_bus_addr, FIRST_LSU ? 32'h0040_0000 : 32'h1001_0000);
    qa.push_back(mk(!FIRST_LSU, 32'h3333_4444, cyc + 2));
    nxt();
    a_if_req = 1'b0; a_lsu_req = 1'b0; a_rd = 32'h3333_4444;
    nxt();
    a_rd = JUNK;
    @(negedge clk);
    chk("tie_busy_end", a_busy, 1'b0);
    nxt();
    @(negedge clk);
    chk("tie_if_rdata", a_if_rdata, FIRST_LSU ? 32'h3333_4444 : 32'h1111_2222);
    chk("tie_lsu_rdata", a_lsu_rdata, FIRST_LSU ? 32'h1111_2222 : 32'h3333_4444);

    // RD_LATENCY=3 LSU load.
    nxt();
    b_lsu_req = 1'b1; b_lsu_wren = 1'b0; b_lsu_addr = 32'h1001_0010;
    @(negedge clk);
    chk("l3_gnt", b_lsu_gnt, 1'b1);
    chk("l3_addr_c0", b_bus_addr, 32'h1001_0010);
    chk("l3_busy_c0", b_busy, 1'b0);
    qb.push_back(mk(1'b1, 32'h3333_3333, cyc + 4));
    for (int i = 1; i <= 3; i++) begin
      nxt();
      b_lsu_req = 1'b0;
      b_rd = {8{i[3:0]}};
      @(negedge clk);
      chk("l3_addr_hold", b_bus_addr, 32'h1001_0010);
      chk("l3_busy", b_busy, 1'b1);
    end
    nxt();
    b_rd = JUNK;
    @(negedge clk);
    chk("l3_busy_c4", b_busy, 1'b0);
    chk("l3_if_rdata_kept", b_if_rdata, 32'h0);

    // Reset in cycle 1 of an RD_LATENCY=3 fetch.
    nxt();
    b_if_req = 1'b1; b_if_addr = 32'h0040_0020;
    @(negedge clk);
    chk("mr_gnt", b_if_gnt, 1'b1);
    nxt();
    b_if_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("mr_busy_before", b_busy, 1'b1);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_busy_after", b_busy, 1'b0);
    chk("mr_addr_after", b_bus_addr, 32'h0);
    chk("mr_lsu_rdata_after", b_lsu_rdata, 32'h0);
    repeat (5) nxt();
    b_if_req = 1'b1; b_if_addr = 32'h0040_0040;
    @(negedge clk);
    chk("mr_new_gnt", b_if_gnt, 1'b1);
    chk("mr_new_addr", b_bus_addr, 32'h0040_0040);
    qb.push_back(mk(1'b0, 32'h4444_4444, cyc + 4));
    nxt();
    b_if_req = 1'b0; b_rd = 32'h0000_0001;
    nxt();
    b_rd = 32'h0000_0002;
    nxt();
    b_rd = 32'h4444_4444;
    nxt();
    b_rd = JUNK;
    repeat (3) nxt();
    @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
